// File: rtl/iact_glb_stream_pkg.sv
// Shared constants and FSM encoding for the iact GLB streaming block.
package iact_glb_stream_pkg;
  localparam int IACT_ADDR_W = 7;
  localparam int IACT_DATA_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } iact_state_e;
endpackage

// File: rtl/iact_glb_stream_if.sv
// SRAM read ports and router output streams of iact_glb_stream, bundled as one interface.
interface iact_glb_stream_if #(
  parameter int ADDR_DEPTH = 16,
  parameter int DATA_DEPTH = 128
);
  import iact_glb_stream_pkg::*;

  localparam int ADDR_IDX_W = $clog2(ADDR_DEPTH);
  localparam int DATA_IDX_W = $clog2(DATA_DEPTH);

  logic                   addr_sram_rd_en;
  logic [ADDR_IDX_W-1:0]  addr_sram_rd_idx;
  logic [IACT_ADDR_W-1:0] addr_sram_rd_data;
  logic                   data_sram_rd_en;
  logic [DATA_IDX_W-1:0]  data_sram_rd_idx;
  logic [IACT_DATA_W-1:0] data_sram_rd_data;

  logic                   address_out_valid;
  logic                   address_out_ready;
  logic [IACT_ADDR_W-1:0] address_out;
  logic                   data_out_valid;
  logic                   data_out_ready;
  logic [IACT_DATA_W-1:0] data_out;

  modport master (
    output addr_sram_rd_en, addr_sram_rd_idx, input addr_sram_rd_data,
    output data_sram_rd_en, data_sram_rd_idx, input data_sram_rd_data,
    output address_out_valid, address_out, input address_out_ready,
    output data_out_valid, data_out, input data_out_ready
  );

  modport slave (
    input addr_sram_rd_en, addr_sram_rd_idx, output addr_sram_rd_data,
    input data_sram_rd_en, data_sram_rd_idx, output data_sram_rd_data,
    input address_out_valid, address_out, output address_out_ready,
    input data_out_valid, data_out, output data_out_ready
  );
endinterface

// File: rtl/iact_stream_fifo2.sv
// Two-entry FIFO with simultaneous push/pop; storage clears on reset so the head reads 0.
module iact_stream_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] mem_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_reg != 2'd0);
  assign do_push = push && ((count_reg != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= wdata;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (do_pop) rd_ptr_reg <= ~rd_ptr_reg;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;
endmodule

// File: rtl/iact_glb_stream.sv
// Streams iact address/data words from two GLB SRAM banks to the router ports.
// Optional backpressure counter enabled by defining IACT_STREAM_STALL_CNT_EN.
module iact_glb_stream #(
  parameter int ADDR_DEPTH = 16,
  parameter int DATA_DEPTH = 128
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [$clog2(ADDR_DEPTH+1)-1:0] addr_len,
  input  logic [$clog2(DATA_DEPTH+1)-1:0] data_len,
  output logic                            busy,
  output logic                            done,
  output logic [15:0]                     stall_cycles,
  iact_glb_stream_if.master               bus
);
  import iact_glb_stream_pkg::*;

  localparam int A_LEN_W = $clog2(ADDR_DEPTH+1);
  localparam int D_LEN_W = $clog2(DATA_DEPTH+1);
  localparam int A_IDX_W = $clog2(ADDR_DEPTH);
  localparam int D_IDX_W = $clog2(DATA_DEPTH);

  iact_state_e state_reg, state_next;
  logic accept;
  logic run;

  assign accept = (state_reg == IDLE) && start;
  assign run    = (state_reg == RUN);

  // Address channel
  logic [A_LEN_W-1:0]     a_len_reg, a_rd_cnt_reg, a_out_cnt_reg;
  logic                   a_inflight_reg, a_pop, a_fin;
  logic [1:0]             a_count;
  logic [IACT_ADDR_W-1:0] a_head;

  assign bus.address_out_valid = (a_count != 2'd0);
  assign bus.address_out       = a_head;
  assign a_pop = bus.address_out_valid && bus.address_out_ready;
  // Credit counts the slot freed by this cycle's pop, which keeps one word per cycle.
  assign bus.addr_sram_rd_en  = run && (a_rd_cnt_reg < a_len_reg) &&
                                ((a_count + {1'b0, a_inflight_reg}) <= ({1'b0, a_pop} + 2'd1));
  assign bus.addr_sram_rd_idx = bus.addr_sram_rd_en ? a_rd_cnt_reg[A_IDX_W-1:0] : '0;
  assign a_fin = (a_out_cnt_reg == a_len_reg) ||
                 (a_pop && ((a_out_cnt_reg + A_LEN_W'(1)) == a_len_reg));

  always_ff @(posedge clk) begin
    if (reset) begin
      a_len_reg      <= '0;
      a_rd_cnt_reg   <= '0;
      a_out_cnt_reg  <= '0;
      a_inflight_reg <= 1'b0;
    end else begin
      a_inflight_reg <= bus.addr_sram_rd_en;
      if (accept) begin
        a_len_reg     <= addr_len;
        a_rd_cnt_reg  <= '0;
        a_out_cnt_reg <= '0;
      end else begin
        if (bus.addr_sram_rd_en) a_rd_cnt_reg <= a_rd_cnt_reg + A_LEN_W'(1);
        if (a_pop) a_out_cnt_reg <= a_out_cnt_reg + A_LEN_W'(1);
      end
    end
  end

  iact_stream_fifo2 #(.WIDTH(IACT_ADDR_W)) u_addr_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (a_inflight_reg),
    .wdata (bus.addr_sram_rd_data),
    .pop   (a_pop),
    .head  (a_head),
    .count (a_count)
  );

  // Data channel
  logic [D_LEN_W-1:0]     d_len_reg, d_rd_cnt_reg, d_out_cnt_reg;
  logic                   d_inflight_reg, d_pop, d_fin;
  logic [1:0]             d_count;
  logic [IACT_DATA_W-1:0] d_head;

  assign bus.data_out_valid = (d_count != 2'd0);
  assign bus.data_out       = d_head;
  assign d_pop = bus.data_out_valid && bus.data_out_ready;
  assign bus.data_sram_rd_en  = run && (d_rd_cnt_reg < d_len_reg) &&
                                ((d_count + {1'b0, d_inflight_reg}) <= ({1'b0, d_pop} + 2'd1));
  assign bus.data_sram_rd_idx = bus.data_sram_rd_en ? d_rd_cnt_reg[D_IDX_W-1:0] : '0;
  assign d_fin = (d_out_cnt_reg == d_len_reg) ||
                 (d_pop && ((d_out_cnt_reg + D_LEN_W'(1)) == d_len_reg));

  always_ff @(posedge clk) begin
    if (reset) begin
      d_len_reg      <= '0;
      d_rd_cnt_reg   <= '0;
      d_out_cnt_reg  <= '0;
      d_inflight_reg <= 1'b0;
    end else begin
      d_inflight_reg <= bus.data_sram_rd_en;
      if (accept) begin
        d_len_reg     <= data_len;
        d_rd_cnt_reg  <= '0;
        d_out_cnt_reg <= '0;
      end else begin
        if (bus.data_sram_rd_en) d_rd_cnt_reg <= d_rd_cnt_reg + D_LEN_W'(1);
        if (d_pop) d_out_cnt_reg <= d_out_cnt_reg + D_LEN_W'(1);
      end
    end
  end

  iact_stream_fifo2 #(.WIDTH(IACT_DATA_W)) u_data_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (d_inflight_reg),
    .wdata (bus.data_sram_rd_data),
    .pop   (d_pop),
    .head  (d_head),
    .count (d_count)
  );

  // Completion looks ahead through the current pop so done follows the last beat by one cycle.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (a_fin && d_fin) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = run;
  assign done = (state_reg == DONE);

`ifdef IACT_STREAM_STALL_CNT_EN
  logic [15:0] stall_reg;
  logic        stalled;

  assign stalled = run && ((bus.address_out_valid && !bus.address_out_ready) ||
                           (bus.data_out_valid && !bus.data_out_ready));

  always_ff @(posedge clk) begin
    if (reset)                              stall_reg <= 16'd0;
    else if (accept)                        stall_reg <= 16'd0;
    else if (stalled && stall_reg != 16'hFFFF) stall_reg <= stall_reg + 16'd1;
  end

  assign stall_cycles = stall_reg;
`else
  assign stall_cycles = 16'd0;
`endif
endmodule

// File: tb/tb_iact_glb_stream.sv
// Directed bench for iact_glb_stream: latency, backpressure, zero length, ignored restart, mid-run reset.
module tb_iact_glb_stream;
  import iact_glb_stream_pkg::*;

  localparam int ADDR_DEPTH = 16;
  localparam int DATA_DEPTH = 128;
  localparam int A_LEN_W = $clog2(ADDR_DEPTH+1);
  localparam int D_LEN_W = $clog2(DATA_DEPTH+1);

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [A_LEN_W-1:0] addr_len = '0;
  logic [D_LEN_W-1:0] data_len = '0;
  logic               busy;
  logic               done;
  logic [15:0]        stall_cycles;

  iact_glb_stream_if #(.ADDR_DEPTH(ADDR_DEPTH), .DATA_DEPTH(DATA_DEPTH)) bus ();

  iact_glb_stream #(.ADDR_DEPTH(ADDR_DEPTH), .DATA_DEPTH(DATA_DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .addr_len     (addr_len),
    .data_len     (data_len),
    .busy         (busy),
    .done         (done),
    .stall_cycles (stall_cycles),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  function automatic int addr_word(input int i);
    return (i * 3 + 5) % 128;
  endfunction

  function automatic int data_word(input int i);
    return (i * 37 + 100) % 4096;
  endfunction

  // SRAM banks: registered read, data one cycle after rd_en
  always @(posedge clk) begin
    if (bus.addr_sram_rd_en)
      bus.addr_sram_rd_data <= IACT_ADDR_W'(addr_word(int'(bus.addr_sram_rd_idx)));
    if (bus.data_sram_rd_en)
      bus.data_sram_rd_data <= IACT_DATA_W'(data_word(int'(bus.data_sram_rd_idx)));
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int a_k_q[$];
  int a_v_q[$];
  int d_k_q[$];
  int d_v_q[$];
  int done_cnt, done_k, busy_cnt, a_valid_cnt, post_valid_cnt, post_busy_cnt;

  function automatic logic rdy(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  // k counts rising edges after the one that accepts start.
  task automatic run_xfer(input int alen, input int dlen, input int a_mode, input int d_mode,
                          input int ncyc, input int mid_k, input int rst_k);
    a_k_q.delete(); a_v_q.delete(); d_k_q.delete(); d_v_q.delete();
    done_cnt = 0; done_k = -1; busy_cnt = 0; a_valid_cnt = 0;
    post_valid_cnt = 0; post_busy_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    addr_len = A_LEN_W'(alen);
    data_len = D_LEN_W'(dlen);
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      start = (k == mid_k);
      if (k == mid_k) begin
        addr_len = A_LEN_W'(1);
        data_len = D_LEN_W'(1);
      end
      reset = (k == rst_k);
      bus.address_out_ready = rdy(a_mode, k);
      bus.data_out_ready    = rdy(d_mode, k);
      @(negedge clk);
      if (bus.address_out_valid) a_valid_cnt++;
      if (bus.address_out_valid && bus.address_out_ready) begin
        a_k_q.push_back(k);
        a_v_q.push_back(int'(bus.address_out));
      end
      if (bus.data_out_valid && bus.data_out_ready) begin
        d_k_q.push_back(k);
        d_v_q.push_back(int'(bus.data_out));
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_k = k;
      end
      if (rst_k >= 0 && k > rst_k) begin
        if (bus.address_out_valid || bus.data_out_valid) post_valid_cnt++;
        if (busy) post_busy_cnt++;
      end
    end
    start = 1'b0;
    reset = 1'b0;
    $display("xfer alen=%0d dlen=%0d abeats=%0d dbeats=%0d done_cnt=%0d done_k=%0d stall=%0d",
             alen, dlen, a_k_q.size(), d_k_q.size(), done_cnt, done_k, stall_cycles);
  endtask

  // Ready held high: beat i of each channel lands at k=2+i.
  task automatic expect_std(input string tag, input int alen, input int dlen, input int done_at);
    check({tag, "_a_beats"}, a_k_q.size(), alen);
    for (int i = 0; i < alen; i++) begin
      check($sformatf("%s_a_cyc%0d", tag, i), (i < a_k_q.size()) ? a_k_q[i] : -1, 2 + i);
      check($sformatf("%s_a_word%0d", tag, i), (i < a_v_q.size()) ? a_v_q[i] : -1, addr_word(i));
    end
    check({tag, "_d_beats"}, d_k_q.size(), dlen);
    for (int i = 0; i < dlen; i++) begin
      check($sformatf("%s_d_cyc%0d", tag, i), (i < d_k_q.size()) ? d_k_q[i] : -1, 2 + i);
      check($sformatf("%s_d_word%0d", tag, i), (i < d_v_q.size()) ? d_v_q[i] : -1, data_word(i));
    end
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_k"}, done_k, done_at);
    check({tag, "_busy_cnt"}, busy_cnt, done_at);
  endtask

  int exp_stall;

  initial begin
    bus.address_out_ready = 1'b1;
    bus.data_out_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_a_valid", int'(bus.address_out_valid), 0);
    check("rst_d_valid", int'(bus.data_out_valid), 0);
    check("rst_a_rd_en", int'(bus.addr_sram_rd_en), 0);
    check("rst_d_rd_en", int'(bus.data_sram_rd_en), 0);
    check("rst_a_idx", int'(bus.addr_sram_rd_idx), 0);
    check("rst_d_idx", int'(bus.data_sram_rd_idx), 0);
    check("rst_a_out", int'(bus.address_out), 0);
    check("rst_d_out", int'(bus.data_out), 0);
    check("rst_stall", int'(stall_cycles), 0);

    // Basic latency and throughput
    run_xfer(3, 5, 0, 0, 12, -1, -1);
    expect_std("basic", 3, 5, 7);

    // Data ready toggling; stalls at k=3,5,7
    run_xfer(0, 4, 0, 1, 14, -1, -1);
    check("tog_d_beats", d_k_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tog_d_cyc%0d", i), (i < d_k_q.size()) ? d_k_q[i] : -1, 2 + 2 * i);
      check($sformatf("tog_d_word%0d", i), (i < d_v_q.size()) ? d_v_q[i] : -1, data_word(i));
    end
    check("tog_done_cnt", done_cnt, 1);
    check("tog_done_k", done_k, 9);
`ifdef IACT_STREAM_STALL_CNT_EN
    exp_stall = 3;
`else
    exp_stall = 0;
`endif
    check("tog_stall", int'(stall_cycles), exp_stall);

    // Zero-length address channel; also clears the stall counter on start
    run_xfer(0, 2, 0, 0, 10, -1, -1);
    check("zero_a_valid_cnt", a_valid_cnt, 0);
    expect_std("zero", 0, 2, 4);
    check("zero_stall", int'(stall_cycles), 0);

    // Restart mid-run must be ignored
    run_xfer(3, 5, 0, 0, 14, 3, -1);
    expect_std("restart", 3, 5, 7);

    // Reset with address FIFO full and a data read in flight
    run_xfer(3, 5, 2, 0, 10, -1, 3);
    check("rstmid_pre_dbeats", d_k_q.size(), 2);
    check("rstmid_post_valid", post_valid_cnt, 0);
    check("rstmid_post_busy", post_busy_cnt, 0);
    check("rstmid_done_cnt", done_cnt, 0);

    run_xfer(3, 5, 0, 0, 12, -1, -1);
    expect_std("after_rst", 3, 5, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
